// File: rtl/cfs_synch_filter_pkg.sv
// Shared constants and helpers for the synchronise-and-filter block.
package cfs_synch_filter_pkg;

  localparam int MIN_STAGES     = 2;
  localparam int MIN_FILTER_CNT = 1;

  // Width of a counter that must hold the values 0 .. filter_cnt.
  function automatic int cnt_width(input int filter_cnt);
    return $clog2(filter_cnt + 1);
  endfunction

endpackage

// File: rtl/cfs_synch_filter_bit.sv
// One channel: flop-chain synchroniser, persistence counter, filtered
// output flop and registered rise/fall pulses.
module cfs_synch_filter_bit
  import cfs_synch_filter_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_CNT = 4,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i,
  output logic o,
  output logic rise,
  output logic fall,
  output logic upd
);

  localparam int             CW       = cnt_width(FILTER_CNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CNT - 1);

  logic [STAGES-1:0] chain;
  logic              s;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              o_nxt;
  logic              rise_nxt;
  logic              fall_nxt;

  assign s   = chain[STAGES-1];
  // Tells the top level an edge pulse will be registered on this clock.
  assign upd = rise_nxt | fall_nxt;

  // Synchroniser chain; stage 0 samples the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= {STAGES{RESET_VAL}};
    else       chain <= {chain[STAGES-2:0], i};
  end

  // Filter decision: o only follows s after FILTER_CNT consecutive mismatches.
  always_comb begin
    cnt_nxt  = cnt;
    o_nxt    = o;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (s == o) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      o_nxt    = s;
      cnt_nxt  = '0;
      rise_nxt = s;
      fall_nxt = ~s;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Counter, filtered output and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      o    <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      o    <= o_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

endmodule

// File: rtl/cfs_synch_filter.sv
// Multi-channel synchroniser with per-channel glitch filter and
// registered edge pulses; changed flags any edge on any channel.
module cfs_synch_filter
  import cfs_synch_filter_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STAGES     = 2,
  parameter int                    FILTER_CNT = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i,
  output logic [DATA_WIDTH-1:0] o,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic                  changed
);

  if (STAGES < MIN_STAGES) begin : g_stages_err
    $error("cfs_synch_filter: STAGES must be at least %0d", MIN_STAGES);
  end
  if (FILTER_CNT < MIN_FILTER_CNT) begin : g_filter_err
    $error("cfs_synch_filter: FILTER_CNT must be at least %0d", MIN_FILTER_CNT);
  end

  logic [DATA_WIDTH-1:0] upd;

  for (genvar n = 0; n < DATA_WIDTH; n++) begin : g_ch
    cfs_synch_filter_bit #(
      .STAGES     (STAGES),
      .FILTER_CNT (FILTER_CNT),
      .RESET_VAL  (RESET_VAL[n])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .i     (i[n]),
      .o     (o[n]),
      .rise  (rise[n]),
      .fall  (fall[n]),
      .upd   (upd[n])
    );
  end

  // Registered from the channels' next-state pulses so it lines up with rise/fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) changed <= 1'b0;
    else       changed <= |upd;
  end

endmodule

// File: tb/tb_cfs_synch_filter.sv
// Self-checking bench for cfs_synch_filter: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// history-window reference model.
module tb_cfs_synch_filter;

  localparam int         S  = 2;
  localparam int         FC = 4;
  localparam logic [7:0] RV = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i, o, rise, fall;
  logic       changed;
  logic       reset2;
  logic [7:0] i2, o2, rise2, fall2;
  logic       changed2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cfs_synch_filter #(
    .DATA_WIDTH (8),
    .STAGES     (S),
    .FILTER_CNT (FC),
    .RESET_VAL  (RV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i       (i),
    .o       (o),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  cfs_synch_filter #(
    .DATA_WIDTH (8),
    .STAGES     (3),
    .FILTER_CNT (1),
    .RESET_VAL  (8'hAA)
  ) dut2 (
    .clk     (clk),
    .reset   (reset2),
    .i       (i2),
    .o       (o2),
    .rise    (rise2),
    .fall    (fall2),
    .changed (changed2)
  );

  typedef struct {
    logic [7:0] i;
    logic [7:0] o;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       ch;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [7:0] ao, input logic [7:0] ar,
                     input logic [7:0] af, input logic ac,
                     input logic [7:0] eo, input logic [7:0] er,
                     input logic [7:0] ef, input logic ec);
    checks++;
    if ({ao, ar, af, ac} !== {eo, er, ef, ec}) begin
      failures++;
      $display("FAIL %s: o/rise/fall/changed got %h/%h/%h/%b expected %h/%h/%h/%b",
               name, ao, ar, af, ac, eo, er, ef, ec);
    end
  endtask

  // Reference model: o[n] flips when the synchronised value seen at each of
  // the last FC edges differed from o[n]; synchronised value at an edge is
  // the input sampled S edges earlier.
  logic [7:0] ihist[$];
  logic [7:0] mo, mr, mf;
  logic       mc;

  task automatic model_reset();
    ihist.delete();
    for (int k = 0; k < S + FC; k++) ihist.push_back(RV);
    mo = RV;
    mr = '0;
    mf = '0;
    mc = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] x);
    logic [7:0] no;
    logic       all_diff;
    ihist.push_front(x);
    void'(ihist.pop_back());
    no = mo;
    for (int b = 0; b < 8; b++) begin
      all_diff = 1'b1;
      for (int w = 0; w < FC; w++) begin
        if (ihist[S + w][b] == mo[b]) all_diff = 1'b0;
      end
      if (all_diff) no[b] = ~mo[b];
    end
    mr = no & ~mo;
    mf = ~no & mo;
    mc = |(mr | mf);
    mo = no;
  endtask

  initial begin
    vec_t       v;
    logic [31:0] r;

    // Table: entry n is the input driven before edge n after reset release
    // and the outputs required just after that edge.
    for (int n = 1; n <= 21; n++) begin
      v.i    = (n <= 3) ? 8'h02 : (n <= 8) ? 8'h00 : (n <= 15) ? 8'hF0 : 8'h0F;
      v.o    = (n < 14) ? 8'h00 : (n < 21) ? 8'hF0 : 8'h0F;
      v.rise = (n == 14) ? 8'hF0 : (n == 21) ? 8'h0F : 8'h00;
      v.fall = (n == 21) ? 8'hF0 : 8'h00;
      v.ch   = (n == 14) || (n == 21);
      tbl.push_back(v);
    end

    reset  = 1'b1;
    i      = 8'h00;
    reset2 = 1'b1;
    i2     = 8'h55;
    #1;
    chk("reset_state", o, rise, fall, changed, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("reset_state2", o2, rise2, fall2, changed2, 8'hAA, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);

    // Glitch on i[1], then simultaneous 0x00->0xF0 and 0xF0->0x0F.
    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clk);
      reset = 1'b0;
      i     = tbl[n].i;
      @(posedge clk);
      #1;
      chk($sformatf("table[%0d]", n + 1), o, rise, fall, changed,
          tbl[n].o, tbl[n].rise, tbl[n].fall, tbl[n].ch);
    end

    // Asynchronous reset while pulses are high, i=0xFF.
    #2;
    i     = 8'hFF;
    reset = 1'b1;
    #1;
    chk("reset_async", o, rise, fall, changed, 8'h00, 8'h00, 8'h00, 1'b0);

    // Latency: 0x00->0x01 before edge k updates o at edge k+5.
    @(negedge clk);
    i = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    i     = 8'h01;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e < 5)       chk($sformatf("latency_k+%0d", e), o, rise, fall, changed, 8'h00, 8'h00, 8'h00, 1'b0);
      else if (e == 5) chk("latency_k+5", o, rise, fall, changed, 8'h01, 8'h01, 8'h00, 1'b1);
      else             chk("latency_k+6", o, rise, fall, changed, 8'h01, 8'h00, 8'h00, 1'b0);
    end

    // Reset mid-count discards progress on i[2].
    @(negedge clk);
    reset = 1'b1;
    i     = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    i     = 8'h04;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midcount_pre_k+%0d", e), o, rise, fall, changed, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midcount_reset", o, rise, fall, changed, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      @(posedge clk);
      #1;
      if (e < 5) chk($sformatf("midcount_post_k+%0d", e), o, rise, fall, changed, 8'h00, 8'h00, 8'h00, 1'b0);
      else       chk("midcount_post_k+5", o, rise, fall, changed, 8'h04, 8'h04, 8'h00, 1'b1);
    end

    // Unfiltered instance: STAGES=3, FILTER_CNT=1, reset value 0xAA, i=0x55.
    @(negedge clk);
    reset2 = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e < 3)       chk($sformatf("unfiltered_k+%0d", e), o2, rise2, fall2, changed2, 8'hAA, 8'h00, 8'h00, 1'b0);
      else if (e == 3) chk("unfiltered_k+3", o2, rise2, fall2, changed2, 8'h55, 8'h55, 8'hAA, 1'b1);
      else             chk("unfiltered_k+4", o2, rise2, fall2, changed2, 8'h55, 8'h00, 8'h00, 1'b0);
    end

    // Randomized run against the reference model.
    @(negedge clk);
    reset = 1'b1;
    i     = 8'h00;
    model_reset();
    #1;
    chk("rnd_start", o, rise, fall, changed, mo, mr, mf, mc);
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        chk($sformatf("rnd_reset[%0d]", n), o, rise, fall, changed, mo, mr, mf, mc);
      end else begin
        reset = 1'b0;
        r     = $urandom & $urandom & $urandom;
        i     = i ^ r[7:0];
      end
      @(posedge clk);
      if (!reset) begin
        model_step(i);
        #1;
        chk($sformatf("rnd[%0d]", n), o, rise, fall, changed, mo, mr, mf, mc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
